led_pattern_gen: RTL and testbench



---
 rtl/led_pkg.sv | 17 +
 rtl/led_channel.sv | 63 ++++++
 rtl/led_pattern_gen.sv | 100 ++++++++++
 tb/tb_led_pattern_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the multi-channel LED pattern generator.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_e;

    localparam int DEFAULT_TICK_DIV = 12000;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its configuration and produces the unpolarised state bit.
module led_channel
    import led_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int DUTY_W   = 8
)(
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic [1:0]          i_mode,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic [DUTY_W-1:0]   i_duty,
    input  logic                i_tick,
    input  logic [DUTY_W-1:0]   i_pwm_cnt,
    output logic                o_state
);

    led_mode_e           r_mode;
    logic [PERIOD_W-1:0] r_period;
    logic [DUTY_W-1:0]   r_duty;
    logic [PERIOD_W-1:0] r_ph_cnt;
    logic                r_blink;
    logic [PERIOD_W-1:0] w_last;

    // A zero half-period behaves like one tick.
    assign w_last = (r_period == '0) ? '0 : r_period - PERIOD_W'(1);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= LED_OFF;
            r_period <= '0;
            r_duty   <= '0;
            r_ph_cnt <= '0;
            r_blink  <= 1'b0;
        end else if (i_load) begin
            r_mode   <= led_mode_e'(i_mode);
            r_period <= i_period;
            r_duty   <= i_duty;
            r_ph_cnt <= '0;
            r_blink  <= 1'b0;
        end else if (r_mode == LED_BLINK && i_tick) begin
            if (r_ph_cnt == w_last) begin
                r_ph_cnt <= '0;
                r_blink  <= ~r_blink;
            end else begin
                r_ph_cnt <= r_ph_cnt + PERIOD_W'(1);
            end
        end
    end

    always_comb begin
        o_state = 1'b0;
        case (r_mode)
            LED_OFF:   o_state = 1'b0;
            LED_ON:    o_state = 1'b1;
            LED_BLINK: o_state = r_blink;
            LED_PWM:   o_state = (i_pwm_cnt < r_duty);
            default:   o_state = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared prescaler and PWM counter, per-channel
// mode engines, a valid/ready config port and polarity-corrected outputs.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int                NUM_CH   = 2,
    parameter int                TICK_DIV = DEFAULT_TICK_DIV,
    parameter int                PERIOD_W = 16,
    parameter int                DUTY_W   = 8,
    parameter logic [NUM_CH-1:0] LED_INV  = '0,
    localparam int               CH_W     = ch_width(NUM_CH)
)(
    input  logic                sysclk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [DUTY_W-1:0]   cfg_duty,
    output logic                cfg_err,
    output logic                tick,
    output logic [NUM_CH-1:0]   led_out
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0]  r_pre_cnt;
    logic [DUTY_W-1:0] r_pwm_cnt;
    logic              r_ready;
    logic              r_err;
    logic [NUM_CH-1:0] r_led;

    logic              w_tick;
    logic              w_accept;
    logic              w_ch_ok;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_state;

    assign w_tick = (r_pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
            r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
        end
    end

    // Handshake: a write is taken on any edge where cfg_valid && cfg_ready.
    // The following cycle is a commit cycle with cfg_ready low, during which
    // the cfg_* inputs are ignored; cfg_ready then returns high.
    assign w_accept = cfg_valid & r_ready;
    assign w_ch_ok  = ({{(32-CH_W){1'b0}}, cfg_ch} < 32'(NUM_CH));

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= ~w_accept;
            r_err   <= w_accept & ~w_ch_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_load[i] = w_accept & (cfg_ch == CH_W'(i));

        led_channel #(
            .PERIOD_W (PERIOD_W),
            .DUTY_W   (DUTY_W)
        ) u_ch (
            .sysclk    (sysclk),
            .rst_n     (rst_n),
            .i_load    (w_load[i]),
            .i_mode    (cfg_mode),
            .i_period  (cfg_period),
            .i_duty    (cfg_duty),
            .i_tick    (w_tick),
            .i_pwm_cnt (r_pwm_cnt),
            .o_state   (w_state[i])
        );
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= LED_INV;
        end else begin
            r_led <= w_state ^ LED_INV;
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign tick      = w_tick;
    assign led_out   = r_led;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: the driver queues expected
// observations, the monitor pops and compares them on falling edges.
`timescale 1ns/1ps
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int         NUM_CH   = 3;
    localparam int         TICK_DIV = 4;
    localparam int         PERIOD_W = 16;
    localparam int         DUTY_W   = 4;
    localparam logic [2:0] LED_INV  = 3'b010;

    localparam logic [7:0] M_ALL    = 8'h3F;
    localparam logic [7:0] M_NOTICK = 8'h1F;
    localparam logic [7:0] M_NOLED0 = 8'h3E;

    logic                sysclk     = 1'b0;
    logic                rst_n      = 1'b1;
    logic                cfg_valid  = 1'b0;
    logic                cfg_ready;
    logic [1:0]          cfg_ch     = '0;
    logic [1:0]          cfg_mode   = '0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic [DUTY_W-1:0]   cfg_duty   = '0;
    logic                cfg_err;
    logic                tick;
    logic [2:0]          led_out;

    typedef struct packed {
        logic       is_cnt;
        logic [7:0] id;
        logic [7:0] mask;
        logic [7:0] val;
    } exp_t;

    logic [$bits(exp_t)-1:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    led_pattern_gen #(
        .NUM_CH   (NUM_CH),
        .TICK_DIV (TICK_DIV),
        .PERIOD_W (PERIOD_W),
        .DUTY_W   (DUTY_W),
        .LED_INV  (LED_INV)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .cfg_err    (cfg_err),
        .tick       (tick),
        .led_out    (led_out)
    );

    // clock / reset
    always #5 sysclk = ~sysclk;

    function automatic logic [7:0] obs();
        return {2'b00, tick, cfg_err, cfg_ready, led_out};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic push_v(input int id, input logic [7:0] mask, input logic rdy,
                          input logic err, input logic tk, input logic [2:0] led);
        exp_t e;
        e.is_cnt = 1'b0;
        e.id     = 8'(id);
        e.mask   = mask;
        e.val    = {2'b00, tk, err, rdy, led};
        exp_q.push_back(e);
    endtask

    task automatic push_cnt(input int id, input int cnt);
        exp_t e;
        e.is_cnt = 1'b1;
        e.id     = 8'(id);
        e.mask   = 8'hFF;
        e.val    = 8'(cnt);
        exp_q.push_back(e);
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    task automatic drive_cfg(input logic [1:0] ch, input led_mode_e m, input int per, input int duty);
        cfg_ch     = ch;
        cfg_mode   = m;
        cfg_period = PERIOD_W'(per);
        cfg_duty   = DUTY_W'(duty);
        cfg_valid  = 1'b1;
        step();
        cfg_valid  = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input led_mode_e m, input int per, input int duty);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) timeout_fail("wait_ready");
        drive_cfg(ch, m, per, duty);
    endtask

    // Issue the write during a tick cycle so it lands on the tick edge.
    task automatic cfg_write_on_tick(input logic [1:0] ch, input led_mode_e m, input int per, input int duty);
        int n = 0;
        while (!(tick === 1'b1 && cfg_ready === 1'b1) && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) timeout_fail("wait_tick");
        drive_cfg(ch, m, per, duty);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) timeout_fail("drain");
    endtask

    // scoreboard monitor
    initial begin : monitor
        exp_t e;
        int   acc;
        int   win;
        acc = 0;
        win = 0;
        forever begin
            @(negedge sysclk);
            if (exp_q.size() > 0) begin
                e = exp_t'(exp_q[0]);
                if (!e.is_cnt) begin
                    void'(exp_q.pop_front());
                    check($sformatf("sb%0d", e.id), obs() & e.mask, e.val & e.mask);
                end else begin
                    acc += int'(led_out[1] ^ LED_INV[1]);
                    win++;
                    if (win == 16) begin
                        void'(exp_q.pop_front());
                        check($sformatf("pwm_cnt%0d", e.id), 8'(acc), e.val);
                        acc = 0;
                        win = 0;
                    end
                end
            end
        end
    end

    initial begin : driver
        // asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1 check("rst_async", obs(), {2'b00, 1'b0, 1'b0, 1'b0, LED_INV});
        push_v(0, M_ALL, 1'b0, 1'b0, 1'b0, LED_INV);
        repeat (3) step();
        rst_n = 1'b1;
        push_v(1, M_ALL, 1'b0, 1'b0, 1'b0, LED_INV);

        // back-to-back writes with cfg_valid held four cycles
        step();
        cfg_ch = 2'd1; cfg_mode = LED_ON; cfg_valid = 1'b1;
        push_v(10, M_NOTICK, 1'b1, 1'b0, 1'b0, 3'b010);
        step();
        cfg_ch = 2'd2; cfg_mode = LED_ON;
        push_v(11, M_NOTICK, 1'b0, 1'b0, 1'b0, 3'b010);
        step();
        push_v(12, M_NOTICK, 1'b1, 1'b0, 1'b0, 3'b000);
        step();
        push_v(13, M_NOTICK, 1'b0, 1'b0, 1'b0, 3'b000);
        step();
        cfg_valid = 1'b0;
        push_v(14, M_NOTICK, 1'b1, 1'b0, 1'b0, 3'b100);
        step();
        push_v(15, M_NOTICK, 1'b1, 1'b0, 1'b0, 3'b100);

        // out-of-range channel: accepted, error pulse, no LED change
        step();
        cfg_ch = 2'd3; cfg_mode = LED_OFF; cfg_valid = 1'b1;
        push_v(20, M_NOTICK, 1'b1, 1'b0, 1'b0, 3'b100);
        step();
        cfg_valid = 1'b0;
        push_v(21, M_NOTICK, 1'b0, 1'b1, 1'b0, 3'b100);
        step();
        push_v(22, M_NOTICK, 1'b1, 1'b0, 1'b0, 3'b100);
        step();
        push_v(23, M_NOTICK, 1'b1, 1'b0, 1'b0, 3'b100);
        step();
        drain();

        // PWM duty: on-count over any 16 consecutive cycles
        cfg_write(2'd1, LED_PWM, 0, 5);
        step(); step();
        push_cnt(30, 5);
        drain();
        cfg_write(2'd1, LED_PWM, 0, 0);
        step(); step();
        push_cnt(31, 0);
        drain();
        cfg_write(2'd1, LED_PWM, 0, 15);
        step(); step();
        push_cnt(32, 15);
        drain();
        cfg_write(2'd1, LED_OFF, 0, 0);

        // BLINK period 3, written on a tick edge: 13 dark samples, 12 lit, dark
        cfg_write_on_tick(2'd0, LED_BLINK, 3, 0);
        for (int j = 0; j < 27; j++) begin
            push_v(40 + j, M_ALL, j != 0, 1'b0, (j % 4) == 3,
                   {1'b1, 1'b1, (j >= 13 && j <= 24)});
            step();
        end
        drain();

        // collision: ch2 toggles every tick; ch0 is rewritten on a tick edge
        cfg_write_on_tick(2'd2, LED_BLINK, 1, 0);
        cfg_write_on_tick(2'd0, LED_BLINK, 2, 0);
        for (int j = 0; j < 14; j++) begin
            push_v(70 + j, (j == 0) ? M_NOLED0 : M_ALL, j != 0, 1'b0, (j % 4) == 3,
                   {(((j + 3) / 4) % 2) == 1, 1'b1, j >= 9});
            step();
        end
        drain();

        // asynchronous reset between edges while ch0 is lit
        @(negedge sysclk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid", obs(), {2'b00, 1'b0, 1'b0, 1'b0, LED_INV});
        repeat (2) step();
        rst_n = 1'b1;
        push_v(90, M_ALL, 1'b0, 1'b0, 1'b0, LED_INV);
        for (int j = 1; j <= 10; j++) begin
            step();
            push_v(90 + j, M_ALL, 1'b1, 1'b0, (j % 4) == 3, LED_INV);
        end
        step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
